// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch vs. load/store) for one variable-latency memory bus.
// Round-robin on ties, registered bus outputs, one-cycle valid pulses and a sticky timeout flag.
module mem_port_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    output logic          if_stall,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] mem_rdata,
    output logic          mem_valid,
    output logic          mem_stall,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_ack,
    input  logic [DW-1:0] bus_rdata,
    output logic          timeout_err
);

    typedef enum logic [1:0] {IDLE, DBUSY, IBUSY, RESP} state_t;

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    // Abort is taken on the busy cycle where the count would reach TIMEOUT_CYC.
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_D  = 1'b1;

    state_t        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bus_req_q, bus_req_d;
    logic          bus_we_q, bus_we_d;
    logic [AW-1:0] bus_addr_q, bus_addr_d;
    logic [DW-1:0] bus_wdata_q, bus_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] mem_rdata_q, mem_rdata_d;
    logic          if_valid_q, if_valid_d;
    logic          mem_valid_q, mem_valid_d;
    logic          timeout_err_q, timeout_err_d;
    logic          mem_pend;

    assign mem_pend = mem_read | mem_write;

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        bus_req_d     = 1'b0;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        if_rdata_d    = if_rdata_q;
        mem_rdata_d   = mem_rdata_q;
        if_valid_d    = 1'b0;
        mem_valid_d   = 1'b0;
        timeout_err_d = timeout_err_q;

        case (state_q)
            IDLE: begin
                if (mem_pend && (!if_req || last_grant_q == GRANT_IF)) begin
                    state_d      = DBUSY;
                    bus_req_d    = 1'b1;
                    bus_we_d     = mem_write;
                    bus_addr_d   = mem_addr;
                    bus_wdata_d  = mem_wdata;
                    last_grant_d = GRANT_D;
                    cnt_d        = '0;
                end else if (if_req) begin
                    state_d      = IBUSY;
                    bus_req_d    = 1'b1;
                    bus_we_d     = 1'b0;
                    bus_addr_d   = if_addr;
                    bus_wdata_d  = '0;
                    last_grant_d = GRANT_IF;
                    cnt_d        = '0;
                end
            end
            DBUSY, IBUSY: begin
                bus_req_d = 1'b1;
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    state_d   = RESP;
                    if (state_q == DBUSY) begin
                        mem_valid_d = 1'b1;
                        if (!bus_we_q) mem_rdata_d = bus_rdata;
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = bus_rdata;
                    end
                end else if (TIMEOUT_CYC != 0) begin
                    if (cnt_q == TO_LAST) begin
                        bus_req_d     = 1'b0;
                        timeout_err_d = 1'b1;
                        state_d       = RESP;
                        if (state_q == DBUSY) begin
                            mem_valid_d = 1'b1;
                            mem_rdata_d = '0;
                        end else begin
                            if_valid_d = 1'b1;
                            if_rdata_d = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant_q  <= GRANT_IF;
            cnt_q         <= '0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            if_rdata_q    <= '0;
            mem_rdata_q   <= '0;
            if_valid_q    <= 1'b0;
            mem_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            if_rdata_q    <= if_rdata_d;
            mem_rdata_q   <= mem_rdata_d;
            if_valid_q    <= if_valid_d;
            mem_valid_q   <= mem_valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;
    assign if_rdata    = if_rdata_q;
    assign mem_rdata   = mem_rdata_q;
    assign if_valid    = if_valid_q;
    assign mem_valid   = mem_valid_q;
    assign timeout_err = timeout_err_q;
    assign if_stall    = if_req & ~if_valid_q;
    assign mem_stall   = mem_pend & ~mem_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand sequences
// for round-robin fairness, timeout and asynchronous reset mid-transaction.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid, if_stall;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_valid, mem_stall;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .mem_stall(mem_stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .timeout_err(timeout_err)
    );

    typedef struct {
        logic        rst, ifr, rd, wr;
        logic [31:0] ifa, addr, wd;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req, e_we;
        logic [31:0] e_addr, e_wd;
        logic        e_iv, e_mv;
        logic [31:0] e_ird, e_mrd;
        logic        e_is, e_ms, e_to;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int grants, last_cyc, busy_cnt;
        logic prev_req;
        logic done;

        rst = 1'b0; if_req = 1'b0; if_addr = '0; mem_read = 1'b0; mem_write = 1'b0;
        mem_addr = '0; mem_wdata = '0; bus_ack = 1'b0; bus_rdata = '0;

        //          rst ifr rd wr ifa    addr   wd   ack rdata        | req we addr   wd   iv mv ird          mrd          is ms to
        vecs[0]  = '{1, 0, 0, 0, 32'h0,  32'h0,   32'h0, 0, 32'h0,        0, 0, 32'h0,   32'h0, 0, 0, 32'h0,        32'h0,        0, 0, 0};
        vecs[1]  = '{0, 0, 1, 0, 32'h0,  32'h100, 32'h0, 0, 32'h0,        0, 0, 32'h0,   32'h0, 0, 0, 32'h0,        32'h0,        0, 1, 0};
        vecs[2]  = '{0, 0, 1, 0, 32'h0,  32'h100, 32'h0, 1, 32'hDEADBEEF, 1, 0, 32'h100, 32'h0, 0, 0, 32'h0,        32'h0,        0, 1, 0};
        vecs[3]  = '{0, 0, 1, 0, 32'h0,  32'h100, 32'h0, 0, 32'h0,        0, 0, 32'h100, 32'h0, 0, 1, 32'h0,        32'hDEADBEEF, 0, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 32'h0,  32'h0,   32'h0, 0, 32'h0,        0, 0, 32'h100, 32'h0, 0, 0, 32'h0,        32'hDEADBEEF, 0, 0, 0};
        vecs[5]  = '{0, 0, 1, 1, 32'h0,  32'h200, 32'h77, 0, 32'h0,       0, 0, 32'h100, 32'h0, 0, 0, 32'h0,        32'hDEADBEEF, 0, 1, 0};
        vecs[6]  = '{0, 0, 1, 1, 32'h0,  32'h200, 32'h77, 1, 32'h12345678, 1, 1, 32'h200, 32'h77, 0, 0, 32'h0,      32'hDEADBEEF, 0, 1, 0};
        vecs[7]  = '{0, 0, 1, 1, 32'h0,  32'h200, 32'h77, 0, 32'h0,       0, 1, 32'h200, 32'h77, 0, 1, 32'h0,       32'hDEADBEEF, 0, 0, 0};
        vecs[8]  = '{0, 0, 0, 0, 32'h0,  32'h0,   32'h0, 0, 32'h0,        0, 1, 32'h200, 32'h77, 0, 0, 32'h0,       32'hDEADBEEF, 0, 0, 0};
        vecs[9]  = '{1, 0, 0, 0, 32'h0,  32'h0,   32'h0, 0, 32'h0,        0, 0, 32'h0,   32'h0, 0, 0, 32'h0,        32'h0,        0, 0, 0};
        vecs[10] = '{0, 1, 0, 1, 32'h80, 32'h40,  32'h5, 0, 32'h0,        0, 0, 32'h0,   32'h0, 0, 0, 32'h0,        32'h0,        1, 1, 0};
        vecs[11] = '{0, 1, 0, 1, 32'h80, 32'h40,  32'h5, 0, 32'h0,        1, 1, 32'h40,  32'h5, 0, 0, 32'h0,        32'h0,        1, 1, 0};
        vecs[12] = '{0, 1, 0, 1, 32'h80, 32'h40,  32'h5, 0, 32'h0,        1, 1, 32'h40,  32'h5, 0, 0, 32'h0,        32'h0,        1, 1, 0};
        vecs[13] = '{0, 1, 0, 1, 32'h80, 32'h40,  32'h5, 1, 32'hBBBB0000, 1, 1, 32'h40,  32'h5, 0, 0, 32'h0,        32'h0,        1, 1, 0};
        vecs[14] = '{0, 1, 0, 1, 32'h80, 32'h40,  32'h5, 0, 32'h0,        0, 1, 32'h40,  32'h5, 0, 1, 32'h0,        32'h0,        1, 0, 0};
        vecs[15] = '{0, 1, 0, 0, 32'h80, 32'h0,   32'h0, 0, 32'h0,        0, 1, 32'h40,  32'h5, 0, 0, 32'h0,        32'h0,        1, 0, 0};
        vecs[16] = '{0, 1, 0, 0, 32'h80, 32'h0,   32'h0, 0, 32'h0,        1, 0, 32'h80,  32'h0, 0, 0, 32'h0,        32'h0,        1, 0, 0};
        vecs[17] = '{0, 1, 0, 0, 32'h80, 32'h0,   32'h0, 0, 32'h0,        1, 0, 32'h80,  32'h0, 0, 0, 32'h0,        32'h0,        1, 0, 0};
        vecs[18] = '{0, 1, 0, 0, 32'h80, 32'h0,   32'h0, 1, 32'hCAFE0001, 1, 0, 32'h80,  32'h0, 0, 0, 32'h0,        32'h0,        1, 0, 0};
        vecs[19] = '{0, 1, 0, 0, 32'h80, 32'h0,   32'h0, 0, 32'h0,        0, 0, 32'h80,  32'h0, 1, 0, 32'hCAFE0001, 32'h0,        0, 0, 0};
        vecs[20] = '{0, 0, 0, 0, 32'h0,  32'h0,   32'h0, 0, 32'h0,        0, 0, 32'h80,  32'h0, 0, 0, 32'hCAFE0001, 32'h0,        0, 0, 0};

        #2;
        for (int i = 0; i < 21; i++) begin
            rst = vecs[i].rst; if_req = vecs[i].ifr; mem_read = vecs[i].rd;
            mem_write = vecs[i].wr; if_addr = vecs[i].ifa; mem_addr = vecs[i].addr;
            mem_wdata = vecs[i].wd; bus_ack = vecs[i].ack; bus_rdata = vecs[i].rdata;
            #1;
            chk("bus_req",     i, 32'(bus_req),     32'(vecs[i].e_req));
            chk("bus_we",      i, 32'(bus_we),      32'(vecs[i].e_we));
            chk("bus_addr",    i, bus_addr,         vecs[i].e_addr);
            chk("bus_wdata",   i, bus_wdata,        vecs[i].e_wd);
            chk("if_valid",    i, 32'(if_valid),    32'(vecs[i].e_iv));
            chk("mem_valid",   i, 32'(mem_valid),   32'(vecs[i].e_mv));
            chk("if_rdata",    i, if_rdata,         vecs[i].e_ird);
            chk("mem_rdata",   i, mem_rdata,        vecs[i].e_mrd);
            chk("if_stall",    i, 32'(if_stall),    32'(vecs[i].e_is));
            chk("mem_stall",   i, 32'(mem_stall),   32'(vecs[i].e_ms));
            chk("timeout_err", i, 32'(timeout_err), 32'(vecs[i].e_to));
            tick();
        end

        // Fairness: both always requesting, bus acks immediately; grants alternate D, I, ...
        if_req = 1'b1; if_addr = 32'h1000; mem_read = 1'b1; mem_addr = 32'h2000;
        bus_ack = 1'b1; bus_rdata = 32'hA5A50000;
        grants = 0; last_cyc = 0; prev_req = 1'b0; done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            tick();
            if (bus_req && !prev_req) begin
                chk("fair_grant_addr", grants, bus_addr, (grants % 2 == 0) ? 32'h2000 : 32'h1000);
                if (grants > 0) chk("fair_spacing", grants, 32'(c - last_cyc), 32'd3);
                last_cyc = c;
                grants++;
                if (grants == 6) done = 1'b1;
            end
            if (mem_valid) chk("fair_mem_rdata", grants, mem_rdata, 32'hA5A50000);
            prev_req = bus_req;
        end
        chk("fair_grant_count", 0, 32'(grants), 32'd6);
        tick();
        chk("fair_last_if_valid", 0, 32'(if_valid), 32'd1);
        chk("fair_last_if_rdata", 0, if_rdata, 32'hA5A50000);
        if_req = 1'b0; mem_read = 1'b0; bus_ack = 1'b0;
        tick();

        // Timeout: fetch with no ack ever
        if_req = 1'b1; if_addr = 32'h300;
        #1;
        chk("to_err_before", 0, 32'(timeout_err), 32'd0);
        busy_cnt = 0; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            tick();
            if (if_valid) done = 1'b1;
            else if (bus_req) busy_cnt++;
        end
        chk("to_valid_seen", 0, 32'(done), 32'd1);
        chk("to_busy_cycles", 0, 32'(busy_cnt), 32'd4);
        chk("to_if_rdata", 0, if_rdata, 32'h0);
        chk("to_bus_req_low", 0, 32'(bus_req), 32'd0);
        chk("to_err_set", 0, 32'(timeout_err), 32'd1);
        if_req = 1'b0;
        tick();
        mem_read = 1'b1; mem_addr = 32'h400; bus_ack = 1'b1; bus_rdata = 32'h11;
        tick();
        chk("to_next_req", 0, 32'(bus_req), 32'd1);
        tick();
        chk("to_next_valid", 0, 32'(mem_valid), 32'd1);
        chk("to_next_rdata", 0, mem_rdata, 32'h11);
        chk("to_err_sticky", 0, 32'(timeout_err), 32'd1);
        mem_read = 1'b0; bus_ack = 1'b0;
        tick();

        // Asynchronous reset during DBUSY, then the held load is re-granted
        mem_read = 1'b1; mem_addr = 32'h500; bus_rdata = 32'h55;
        tick();
        chk("rst_pre_req", 0, 32'(bus_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_bus_req",   0, 32'(bus_req),     32'd0);
        chk("rst_bus_addr",  0, bus_addr,         32'h0);
        chk("rst_mem_rdata", 0, mem_rdata,        32'h0);
        chk("rst_if_rdata",  0, if_rdata,         32'h0);
        chk("rst_timeout",   0, 32'(timeout_err), 32'd0);
        chk("rst_mem_valid", 0, 32'(mem_valid),   32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("rst_regrant_req",  0, 32'(bus_req),  32'd1);
        chk("rst_regrant_addr", 0, bus_addr,      32'h500);
        chk("rst_no_pulse",     0, 32'(mem_valid), 32'd0);
        bus_ack = 1'b1;
        tick();
        chk("rst_done_valid", 0, 32'(mem_valid), 32'd1);
        chk("rst_done_rdata", 0, mem_rdata,      32'h55);
        mem_read = 1'b0; bus_ack = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
